// File: rtl/led_prog_loader.sv
// led_prog_loader: receives a framed byte stream (HEADER, LEN, 2*LEN data
// bytes, CSUM), assembles 16-bit instructions into a 256x16 program memory
// and holds the LED core in reset until a checksum-valid program is resident.
module led_prog_loader #(
    parameter int         TIMEOUT = 5_000_000,
    parameter logic [7:0] HEADER  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [7:0]  addrRd,
    output logic [15:0] dataRd,
    output logic        cpuRst,
    output logic        loading,
    output logic        progValid,
    output logic        loadErr
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DHI  = 3'd2,
        S_DLO  = 3'd3,
        S_CSUM = 3'd4
    } state_t;

    localparam logic [22:0] TMO = 23'(TIMEOUT);

    // Running checksum update, kept as a helper so the wrap is explicit.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    state_t      state_r, state_s;
    logic [8:0]  words_left_r, words_left_s;
    logic [7:0]  wr_addr_r, wr_addr_s;
    logic [7:0]  sum_r, sum_s;
    logic [7:0]  hi_byte_r, hi_byte_s;
    logic [22:0] tcnt_r, tcnt_s;
    logic        loading_s, prog_valid_s, load_err_s;
    logic        we_s;
    logic [15:0] mem_r [0:255];

    // Program memory is read asynchronously by the core.
    assign dataRd = mem_r[addrRd];

    // Next-state logic: frame parser plus inter-byte timeout.
    always_comb begin
        state_s      = state_r;
        words_left_s = words_left_r;
        wr_addr_s    = wr_addr_r;
        sum_s        = sum_r;
        hi_byte_s    = hi_byte_r;
        tcnt_s       = tcnt_r;
        loading_s    = loading;
        prog_valid_s = progValid;
        load_err_s   = loadErr;
        we_s         = 1'b0;
        if (rx_valid) begin
            // A byte always wins over a timeout on the same cycle.
            tcnt_s = 23'd0;
            case (state_r)
                S_IDLE: begin
                    if (rx_data == HEADER) begin
                        state_s      = S_LEN;
                        load_err_s   = 1'b0;
                        prog_valid_s = 1'b0;
                        loading_s    = 1'b1;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_LEN: begin
                    words_left_s = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    wr_addr_s    = 8'd0;
                    sum_s        = 8'd0;
                    state_s      = S_DHI;
                end
                S_DHI: begin
                    hi_byte_s = rx_data;
                    sum_s     = csum_add(sum_r, rx_data);
                    state_s   = S_DLO;
                end
                S_DLO: begin
                    we_s         = ~rst;
                    sum_s        = csum_add(sum_r, rx_data);
                    wr_addr_s    = wr_addr_r + 8'd1;
                    words_left_s = words_left_r - 9'd1;
                    if (words_left_r == 9'd1) begin
                        state_s = S_CSUM;
                    end else begin
                        state_s = S_DHI;
                    end
                end
                S_CSUM: begin
                    if (rx_data == sum_r) begin
                        prog_valid_s = 1'b1;
                    end else begin
                        load_err_s = 1'b1;
                    end
                    loading_s = 1'b0;
                    state_s   = S_IDLE;
                end
                default: begin
                    state_s   = S_IDLE;
                    loading_s = 1'b0;
                end
            endcase
        end else if (state_r != S_IDLE) begin
            if (tcnt_r == TMO) begin
                // Stalled too long inside a frame: abandon it.
                state_s      = S_IDLE;
                load_err_s   = 1'b1;
                loading_s    = 1'b0;
                prog_valid_s = 1'b0;
                tcnt_s       = 23'd0;
            end else begin
                tcnt_s = tcnt_r + 23'd1;
            end
        end else begin
            tcnt_s = 23'd0;
        end
    end

    // State and registered outputs; core reset follows the next-state view.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            words_left_r <= 9'd0;
            wr_addr_r    <= 8'd0;
            sum_r        <= 8'd0;
            hi_byte_r    <= 8'd0;
            tcnt_r       <= 23'd0;
            loading      <= 1'b0;
            progValid    <= 1'b0;
            loadErr      <= 1'b0;
            cpuRst       <= 1'b1;
        end else begin
            state_r      <= state_s;
            words_left_r <= words_left_s;
            wr_addr_r    <= wr_addr_s;
            sum_r        <= sum_s;
            hi_byte_r    <= hi_byte_s;
            tcnt_r       <= tcnt_s;
            loading      <= loading_s;
            progValid    <= prog_valid_s;
            loadErr      <= load_err_s;
            cpuRst       <= ~prog_valid_s | (state_s != S_IDLE);
        end
    end

    // Memory write port; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[wr_addr_r] <= {hi_byte_r, rx_data};
        end
    end

endmodule

// File: tb/tb_led_prog_loader.sv
// Self-checking bench for led_prog_loader: table-driven frames plus
// hand-written sequences for the 256-word load, timeout and mid-frame reset.
module tb_led_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  addrRd;
    logic [15:0] dataRd;
    logic        cpuRst, loading, progValid, loadErr;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic [7:0]  a;
        logic [3:0]  f;    // {cpuRst, loading, progValid, loadErr}
        logic        chk;
        logic [15:0] dat;
    } vec_t;

    vec_t tbl[$];

    led_prog_loader #(.TIMEOUT(20), .HEADER(8'hA5)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .addrRd(addrRd), .dataRd(dataRd), .cpuRst(cpuRst),
        .loading(loading), .progValid(progValid), .loadErr(loadErr)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic v, input logic [7:0] d, input logic [7:0] a,
                                input logic [3:0] f, input logic chk, input logic [15:0] dat);
        vec_t e;
        e.v = v; e.d = d; e.a = a; e.f = f; e.chk = chk; e.dat = dat;
        tbl.push_back(e);
    endfunction

    task automatic tick(input logic v, input logic [7:0] d, input logic [7:0] a);
        rx_valid = v;
        rx_data  = d;
        addrRd   = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string name, input logic [3:0] exp);
        chk(name, {12'd0, cpuRst, loading, progValid, loadErr}, {12'd0, exp});
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; addrRd = 8'd0;
        tick(1'b0, 8'd0, 8'd0);
        tick(1'b0, 8'd0, 8'd0);
        chk_flags("reset", 4'b1000);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 8'd0, 8'd0);
            chk_flags($sformatf("idle%0d", i), 4'b1000);
        end

        // Good frame, back to back
        add(1, 8'hA5, 8'd0, 4'b1100, 0, 16'h0);
        add(1, 8'h02, 8'd0, 4'b1100, 0, 16'h0);
        add(1, 8'h11, 8'd0, 4'b1100, 0, 16'h0);
        add(1, 8'h05, 8'd0, 4'b1100, 1, 16'h1105);
        add(1, 8'h00, 8'd1, 4'b1100, 0, 16'h0);
        add(1, 8'h00, 8'd1, 4'b1100, 1, 16'h0000);
        add(1, 8'h16, 8'd0, 4'b0010, 1, 16'h1105);
        add(0, 8'h00, 8'd1, 4'b0010, 1, 16'h0000);
        // Bad checksum
        add(1, 8'hA5, 8'd0, 4'b1100, 0, 16'h0);
        add(1, 8'h02, 8'd0, 4'b1100, 0, 16'h0);
        add(1, 8'h11, 8'd0, 4'b1100, 0, 16'h0);
        add(1, 8'h05, 8'd0, 4'b1100, 0, 16'h0);
        add(1, 8'h00, 8'd0, 4'b1100, 0, 16'h0);
        add(1, 8'h00, 8'd0, 4'b1100, 0, 16'h0);
        add(1, 8'h17, 8'd0, 4'b1001, 0, 16'h0);
        add(0, 8'h00, 8'd0, 4'b1001, 0, 16'h0);
        // Good frame with gaps; header clears the error
        add(1, 8'hA5, 8'd0, 4'b1100, 0, 16'h0);
        add(0, 8'h00, 8'd0, 4'b1100, 0, 16'h0);
        add(1, 8'h02, 8'd0, 4'b1100, 0, 16'h0);
        add(1, 8'h11, 8'd0, 4'b1100, 0, 16'h0);
        add(0, 8'h00, 8'd0, 4'b1100, 0, 16'h0);
        add(1, 8'h05, 8'd0, 4'b1100, 1, 16'h1105);
        add(1, 8'h00, 8'd0, 4'b1100, 0, 16'h0);
        add(1, 8'h00, 8'd0, 4'b1100, 0, 16'h0);
        add(1, 8'h16, 8'd0, 4'b0010, 0, 16'h0);
        // Header-valued bytes as data
        add(1, 8'hA5, 8'd0, 4'b1100, 0, 16'h0);
        add(1, 8'h01, 8'd0, 4'b1100, 0, 16'h0);
        add(1, 8'hA5, 8'd0, 4'b1100, 0, 16'h0);
        add(1, 8'hA5, 8'd0, 4'b1100, 1, 16'hA5A5);
        add(1, 8'h4A, 8'd0, 4'b0010, 1, 16'hA5A5);
        // Non-header byte in idle is ignored
        add(1, 8'h33, 8'd0, 4'b0010, 0, 16'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].v, tbl[i].d, tbl[i].a);
            chk_flags($sformatf("vec%0d_flags", i), tbl[i].f);
            if (tbl[i].chk) chk($sformatf("vec%0d_data", i), dataRd, tbl[i].dat);
        end

        // LEN=0: 256 words, byte i = i[7:0], checksum 00
        tick(1'b1, 8'hA5, 8'd0);
        tick(1'b1, 8'h00, 8'd0);
        for (int i = 0; i < 512; i++) tick(1'b1, 8'(i), 8'd0);
        chk_flags("len0_before_csum", 4'b1100);
        tick(1'b1, 8'h00, 8'd0);
        chk_flags("len0_done", 4'b0010);
        for (int k = 0; k < 256; k += 127) begin
            logic [7:0] hb, lb;
            hb = 8'(2 * k);
            lb = 8'(2 * k + 1);
            tick(1'b0, 8'd0, 8'(k));
            chk($sformatf("len0_mem%0d", k), dataRd, {hb, lb});
        end
        tick(1'b1, 8'h33, 8'd0);
        chk_flags("len0_extra_byte", 4'b0010);
        chk("len0_mem0_kept", dataRd, 16'h0001);

        // Stalls of 20 idle cycles do not abort
        tick(1'b1, 8'hA5, 8'd0);
        tick(1'b1, 8'h03, 8'd0);
        tick(1'b1, 8'h11, 8'd0);
        for (int i = 0; i < 20; i++) tick(1'b0, 8'd0, 8'd0);
        chk_flags("stall20_a", 4'b1100);
        tick(1'b1, 8'h22, 8'd0);
        chk_flags("stall20_byte", 4'b1100);
        chk("stall20_mem0", dataRd, 16'h1122);
        tick(1'b1, 8'h33, 8'd0);
        for (int i = 0; i < 20; i++) tick(1'b0, 8'd0, 8'd0);
        tick(1'b1, 8'h44, 8'd1);
        chk("stall20_mem1", dataRd, 16'h3344);
        tick(1'b1, 8'h55, 8'd0);
        tick(1'b1, 8'h66, 8'd2);
        tick(1'b1, 8'h65, 8'd2);
        chk_flags("stall20_done", 4'b0010);
        chk("stall20_mem2", dataRd, 16'h5566);

        // Stall of 25 aborts
        tick(1'b1, 8'hA5, 8'd0);
        tick(1'b1, 8'h03, 8'd0);
        tick(1'b1, 8'h11, 8'd0);
        for (int i = 0; i < 25; i++) tick(1'b0, 8'd0, 8'd0);
        chk_flags("timeout_abort", 4'b1001);

        // Reset in DLO mid-frame
        tick(1'b1, 8'hA5, 8'd0);
        chk_flags("rst_hdr", 4'b1100);
        tick(1'b1, 8'h02, 8'd0);
        tick(1'b1, 8'h11, 8'd0);
        tick(1'b1, 8'h05, 8'd0);
        tick(1'b1, 8'h00, 8'd0);
        rst = 1'b1;
        tick(1'b0, 8'd0, 8'd0);
        rst = 1'b0;
        chk_flags("rst_midframe", 4'b1000);
        tick(1'b1, 8'hA5, 8'd0);
        tick(1'b1, 8'h01, 8'd0);
        tick(1'b1, 8'h12, 8'd0);
        tick(1'b1, 8'h34, 8'd0);
        tick(1'b1, 8'h46, 8'd0);
        chk_flags("after_rst_load", 4'b0010);
        chk("after_rst_mem0", dataRd, 16'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_prog_loader.md
# led_prog_loader

Upstream program-store stage for the LED CPU core. It receives a framed byte stream from a serial receiver and assembles the bytes into 16-bit instructions. It writes them into a 256x16 program memory that the core reads through `addrRd`/`dataRd`, and holds the core in reset until a complete, checksum-valid program is resident. This replaces the fixed ROM and makes LED patterns reloadable at run time.

## Interface
Parameters:
- `TIMEOUT`, default 5_000_000: idle cycles allowed between bytes inside a frame before the frame is aborted. Counter width is 23 bits.
- `HEADER`, default 8'hA5: frame start byte.

Ports:
- `clk`  in  1  system clock. The block uses one clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `rx_data`  in  8  received byte. Valid only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per byte. Strobes may arrive on back-to-back cycles.
- `addrRd`  in  8  core instruction address.
- `dataRd`  out  16  `mem[addrRd]`. Combinational (asynchronous) read.
- `cpuRst`  out  1  reset to the core. Registered.
- `loading`  out  1  1 while a frame is in progress. Registered.
- `progValid`  out  1  1 when the memory holds a fully verified program. Registered.
- `loadErr`  out  1  sticky error flag for the last frame. Registered.

## Operation
- Frame format: `HEADER`, then `LEN` (number of instructions; 0 means 256), then 2*LEN data bytes, then `CSUM`.
  - Each instruction is sent high byte first: pattern or jump target, then duration (0 = jump).
  - `CSUM` is the sum of all 2*LEN data bytes mod 256. The `LEN` byte is excluded.
- State machine, advancing only on `rx_valid`:
  - IDLE: a byte equal to `HEADER` goes to LEN, clears `loadErr` and `progValid`, and sets `loading`. Any other byte is ignored.
  - LEN: latches `wordsLeft = (rx_data==0) ? 256 : rx_data` (9 bits), clears `wrAddr` (8 bits) and `sum` (8 bits), then goes to DHI.
  - DHI: latches `hiByte`, adds the byte to `sum`, then goes to DLO.
  - DLO:
    - Writes `mem[wrAddr] <= {hiByte, rx_data}`, adds the byte to `sum`, increments `wrAddr` and decrements `wordsLeft`.
    - If `wordsLeft` was 1, goes to CSUM. Otherwise goes to DHI.
    - `wrAddr` wraps 255->0 only after the 256th word, which then exits to CSUM.
  - CSUM:
    - If `rx_data == sum`, sets `progValid`=1.
    - Otherwise sets `loadErr`=1.
    - Either way clears `loading` and goes to IDLE.
- Timeout:
  - Outside IDLE, a counter increments each cycle without `rx_valid` and clears on every `rx_valid`.
  - When the count reaches `TIMEOUT`, the frame aborts: go to IDLE, `loadErr`=1, `loading`=0, `progValid` stays 0.
  - If `rx_valid` arrives on the same cycle the count reaches `TIMEOUT`, the byte is accepted and the timeout is ignored.
- A `HEADER`-valued byte inside a frame is treated as data, not as a restart.
- `cpuRst` is registered and computed as `rst | ~progValidNext | (stateNext != IDLE)`.
  - The core is held in reset during loading, after an error, and before the first good load.
- Memory contents are not cleared by `rst`. Words written before an abort or an error remain in memory, but `progValid`=0 keeps the core in reset.
- Reset mid-frame: next cycle the state is IDLE, with `loading`=0, `progValid`=0, `loadErr`=0, `cpuRst`=1, and the counters cleared.

## Timing
- Reset values: `cpuRst`=1, `loading`=0, `progValid`=0, `loadErr`=0, state IDLE, `wrAddr`=0, `sum`=0, timeout count 0.
- The `HEADER` byte accepted at cycle t gives `loading`=1 and `cpuRst`=1 at t+1.
- A word written in the DLO cycle t is visible on `dataRd` from t+1 when `addrRd` selects it.
- A matching `CSUM` at cycle t gives `progValid`=1 and `cpuRst`=0 at t+1. The core starts from address 0 at t+1 (its own reset clears `addrRd`).
- A wrong `CSUM` at cycle t gives `loadErr`=1 at t+1, with `cpuRst` remaining 1.
- Abort happens on the cycle after the count equals `TIMEOUT`; flags update one cycle later.
- Minimum frame time is 2*LEN+3 cycles.

## Test plan
- Reset, then no input for 100 cycles -> `cpuRst`=1, `progValid`=0, `loadErr`=0, `loading`=0 throughout.
- Back-to-back frame A5 02 11 05 00 00 16 -> `mem[0]`=16'h1105 and `mem[1]`=16'h0000; `progValid`=1 and `cpuRst`=0 one cycle after the 16 byte; `dataRd` tracks `addrRd`.
- Same frame with CSUM=17 -> `loadErr`=1, `progValid`=0, `cpuRst`=1. Then a correct frame -> `loadErr` clears on its A5, and `progValid`=1 at the end.
- LEN=00 with 512 data bytes (byte i = i[7:0]) and the correct CSUM -> all 256 words written, `wrAddr` wraps to 0, `progValid`=1. A 513th byte in IDLE is ignored unless it is A5.
- With `TIMEOUT`=20, send A5 03 11 then stall 25 cycles -> abort, with `loadErr`=1, `loading`=0, `cpuRst`=1. A stall of exactly 20 cycles with a byte on the 20th cycle -> no abort.
- Assert `rst` while in DLO mid-frame -> next cycle IDLE with `cpuRst`=1 and all flags 0. A subsequent good frame loads normally.
